// File: rtl/grad_bram_seq.sv
// grad_bram_seq: multi-channel sample sequencer that plays 32-bit words from an
// internal read-first BRAM at a programmable interval, with looping and backpressure.
module grad_bram_seq #(
    parameter int  ADDR_WIDTH    = 13,
    parameter int  CHANNELS      = 4,
    parameter int  DIV_WIDTH     = 10,
    parameter int  PAYLOAD_WIDTH = 24,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic                     wr_en_i,
    input  logic [ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [31:0]              wr_data_i,
    input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
    output logic [31:0]              rd_data_o,
    input  logic [DIV_WIDTH-1:0]     divider_i,
    input  logic [ADDR_WIDTH-1:0]    offset_i,
    input  logic                     data_enb_i,
    input  logic                     loop_i,
    input  logic                     serial_busy_i,
    input  logic                     clr_err_i,
    output logic [PAYLOAD_WIDTH-1:0] data_o,
    output logic [CH_W-1:0]          channel_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o
);

    localparam int CNT_W = DIV_WIDTH + 5;
    localparam int DC_W  = DIV_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMIT, S_HOLD, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     fetch_q, fetch_d, fetch2_q, fetch2_d;
    logic [31:0]              word_q, word_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DC_W-1:0]          dcnt_q, dcnt_d;
    logic [2:0]               cur_dly_q, cur_dly_d;
    logic                     cur_last_q, cur_last_d;
    logic [PAYLOAD_WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]          chan_q, chan_d;
    logic                     valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic                     ovf_q, ovf_d, ovf_set, emit;
    logic [31:0]              rd_data_q;
    logic [31:0]              mem_rd_q;
    logic [31:0]              mem [0:(1<<ADDR_WIDTH)-1];
    logic [DC_W-1:0]          period;
    logic [CNT_W-1:0]         hold_lim;
    logic                     unused_word;

    // Channel/payload bits beyond CH_W/PAYLOAD_WIDTH are ignored by design.
    assign unused_word = ^word_q;

    // Read-first: a same-cycle write lands after the old word has been captured.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (fetch_q) mem_rd_q <= mem[addr_q];
    end

    assign period   = DC_W'(divider_i) + DC_W'(4);
    assign hold_lim = (CNT_W'(cur_dly_q) + CNT_W'(1)) * CNT_W'(period) - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_d    = 1'b0;
        fetch2_d   = fetch_q;
        word_d     = fetch2_q ? mem_rd_q : word_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        cur_dly_d  = cur_dly_q;
        cur_last_d = cur_last_q;
        data_d     = data_q;
        chan_d     = chan_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_set    = 1'b0;
        emit       = 1'b0;

        if (!data_enb_i) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d  = offset_i;
                    fetch_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    dcnt_d = '0;
                    if (fetch2_q) state_d = S_EMIT;
                end
                S_EMIT: begin
                    if (!serial_busy_i) begin
                        emit = 1'b1;
                    end else begin
                        if (dcnt_q != '1) dcnt_d = dcnt_q + DC_W'(1);
                        if ((DC_W+1)'(dcnt_q) + (DC_W+1)'(1) >= (DC_W+1)'(period)) ovf_set = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q >= hold_lim) begin
                        if (cur_last_q && !loop_i) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end else if (!serial_busy_i) begin
                            emit = 1'b1;
                        end else begin
                            dcnt_d  = '0;
                            state_d = S_EMIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end

        // Strobe the prefetched word and start prefetching its successor.
        if (emit) begin
            data_d     = word_q[PAYLOAD_WIDTH-1:0];
            chan_d     = word_q[24 +: CH_W];
            cur_dly_d  = word_q[30:28];
            cur_last_d = word_q[31];
            valid_d    = 1'b1;
            cnt_d      = '0;
            addr_d     = word_q[31] ? offset_i : addr_q + ADDR_WIDTH'(1);
            fetch_d    = 1'b1;
            state_d    = S_HOLD;
        end

        ovf_d = ovf_set ? 1'b1 : (clr_err_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            fetch_q    <= 1'b0;
            fetch2_q   <= 1'b0;
            word_q     <= '0;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            cur_dly_q  <= '0;
            cur_last_q <= 1'b0;
            data_q     <= '0;
            chan_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_q    <= fetch_d;
            fetch2_q   <= fetch2_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            cur_dly_q  <= cur_dly_d;
            cur_last_q <= cur_last_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= mem[rd_addr_i];
        end
    end

    assign rd_data_o  = rd_data_q;
    assign data_o     = data_q;
    assign channel_o  = chan_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_grad_bram_seq.sv
// tb_grad_bram_seq: directed-vector bench for grad_bram_seq with hand-computed
// strobe spacing, payload/channel, loop, backpressure and reset expectations.
module tb_grad_bram_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic [12:0] rd_addr;
    logic [31:0] rd_data;
    logic [9:0]  divider;
    logic [12:0] offset;
    logic        enb, loop_en, sbusy, clr;
    logic [23:0] data;
    logic [1:0]  chan;
    logic        valid, busy, done, ovf;

    int n_vec = 0;
    int n_err = 0;
    int n;
    int seen;

    grad_bram_seq dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .divider_i     (divider),
        .offset_i      (offset),
        .data_enb_i    (enb),
        .loop_i        (loop_en),
        .serial_busy_i (sbusy),
        .clr_err_i     (clr),
        .data_o        (data),
        .channel_o     (chan),
        .valid_o       (valid),
        .busy_o        (busy),
        .done_o        (done),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Ticks until valid (or done) is seen; n = ticks taken, -1 on timeout.
    task automatic wait_evt(input bit on_done, input int max, output int cnt);
        bit hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < max) begin
            tick();
            cnt++;
            hit = on_done ? (done === 1'b1) : (valid === 1'b1);
        end
        if (!hit) cnt = -1;
    endtask

    task automatic ticks_quiet(input int k, output int strobes);
        strobes = 0;
        repeat (k) begin
            tick();
            if (valid === 1'b1) strobes++;
        end
    endtask

    function automatic logic [31:0] mkw(input bit last, input int dly, input int ch, input int pay);
        mkw = {last, 3'(dly), 4'(ch), 24'(pay)};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        divider = '0; offset = '0; enb = 1'b0; loop_en = 1'b0; sbusy = 1'b0; clr = 1'b0;
        tick(); tick();
        chk_eq("rst_valid", valid, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_ovf", ovf, 0);
        chk_eq("rst_data", data, 0);
        chk_eq("rst_chan", chan, 0);
        chk_eq("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Basic run: words 0..9, interval 4
        for (int k = 0; k < 10; k++) wr(13'(k), mkw(k == 9, 0, k % 4, k));
        enb = 1'b1;
        tick();
        chk_eq("basic_busy_start", busy, 1);
        for (int k = 0; k < 10; k++) begin
            wait_evt(1'b0, 10, n);
            chk_eq($sformatf("basic_gap%0d", k), n, (k == 0) ? 3 : 4);
            chk_eq($sformatf("basic_pay%0d", k), data, k);
            chk_eq($sformatf("basic_ch%0d", k), chan, k % 4);
        end
        wait_evt(1'b1, 10, n);
        chk_eq("basic_done_gap", n, 4);
        chk_eq("basic_busy_end", busy, 0);
        tick();
        chk_eq("basic_done_pulse", done, 0);
        enb = 1'b0;
        tick();

        // Delay words and a mid-pause divider change
        wr(20, mkw(0, 0, 1, 'h100));
        wr(21, mkw(0, 2, 2, 'h101));
        wr(22, mkw(0, 0, 3, 'h102));
        wr(23, mkw(1, 0, 0, 'h103));
        divider = 10'd303; offset = 13'd20;
        enb = 1'b1;
        tick();
        wait_evt(1'b0, 10, n);
        chk_eq("dly_first_gap", n, 3);
        chk_eq("dly_first_pay", data, 'h100);
        wait_evt(1'b0, 1000, n);
        chk_eq("dly_gap_307", n, 307);
        chk_eq("dly_pay_101", data, 'h101);
        wait_evt(1'b0, 1000, n);
        chk_eq("dly_gap_921", n, 921);
        chk_eq("dly_pay_102", data, 'h102);
        repeat (100) tick();
        divider = 10'd0;
        wait_evt(1'b0, 400, n);
        chk_eq("div_drop_gap", n, 1);
        chk_eq("div_drop_pay", data, 'h103);
        tick(); tick();
        enb = 1'b0;
        tick();
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_valid", valid, 0);
        chk_eq("abort_data_held", data, 'h103);
        tick();

        // Backpressure: 100-cycle deferral, then 400-cycle deferral
        wr(30, mkw(0, 0, 0, 'h200));
        wr(31, mkw(0, 0, 1, 'h201));
        wr(32, mkw(0, 0, 2, 'h202));
        wr(33, mkw(1, 0, 3, 'h203));
        divider = 10'd303; offset = 13'd30;
        enb = 1'b1;
        tick();
        wait_evt(1'b0, 10, n);
        chk_eq("bp_first_gap", n, 3);
        repeat (306) tick();
        sbusy = 1'b1;
        ticks_quiet(100, seen);
        chk_eq("bp100_no_strobe", seen, 0);
        sbusy = 1'b0;
        wait_evt(1'b0, 10, n);
        chk_eq("bp100_release_gap", n, 1);
        chk_eq("bp100_pay", data, 'h201);
        chk_eq("bp100_ovf", ovf, 0);
        repeat (306) tick();
        sbusy = 1'b1;
        ticks_quiet(400, seen);
        chk_eq("bp400_no_strobe", seen, 0);
        sbusy = 1'b0;
        wait_evt(1'b0, 10, n);
        chk_eq("bp400_release_gap", n, 1);
        chk_eq("bp400_pay", data, 'h202);
        chk_eq("bp400_ovf_set", ovf, 1);
        repeat (5) tick();
        chk_eq("bp400_ovf_sticky", ovf, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_eq("ovf_cleared", ovf, 0);
        enb = 1'b0;
        tick();

        // Loop from offset 2 with last on address 5
        divider = 10'd0; offset = 13'd2; loop_en = 1'b1;
        for (int k = 2; k < 6; k++) wr(13'(k), mkw(k == 5, 0, k % 4, k));
        enb = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            wait_evt(1'b0, 10, n);
            chk_eq($sformatf("loop_gap%0d", k), n, (k == 0) ? 3 : 4);
            chk_eq($sformatf("loop_pay%0d", k), data, 2 + (k % 4));
        end
        enb = 1'b0; loop_en = 1'b0;
        tick();

        // Address wrap from 8190
        wr(8190, mkw(0, 0, 0, 'hAA0));
        wr(8191, mkw(0, 0, 1, 'hAA1));
        wr(0,    mkw(1, 0, 2, 'hAA2));
        offset = 13'd8190;
        enb = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_evt(1'b0, 10, n);
            chk_eq($sformatf("wrap_pay%0d", k), data, 'hAA0 + k);
            chk_eq($sformatf("wrap_ch%0d", k), chan, k);
        end
        wait_evt(1'b1, 10, n);
        chk_eq("wrap_done_gap", n, 4);
        enb = 1'b0;
        tick();

        // Async reset mid-run, then restart at offset
        offset = 13'd2; loop_en = 1'b1;
        enb = 1'b1;
        tick();
        wait_evt(1'b0, 10, n);
        wait_evt(1'b0, 10, n);
        chk_eq("prerst_pay", data, 3);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_valid", valid, 0);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_data", data, 0);
        chk_eq("arst_chan", chan, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_eq("rerun_busy", busy, 1);
        wait_evt(1'b0, 10, n);
        chk_eq("rerun_gap", n, 3);
        chk_eq("rerun_pay", data, 2);
        enb = 1'b0; loop_en = 1'b0;
        tick();

        // Read-first collision on the start address
        wr(40, mkw(1, 0, 1, 'h111));
        offset = 13'd40;
        enb = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 13'd40; wr_data = mkw(1, 0, 3, 'h222);
        tick();
        wr_en = 1'b0;
        wait_evt(1'b0, 10, n);
        chk_eq("coll_gap", n, 2);
        chk_eq("coll_old_pay", data, 'h111);
        chk_eq("coll_old_ch", chan, 1);
        rd_addr = 13'd40;
        tick();
        chk_eq("coll_readback", rd_data, mkw(1, 0, 3, 'h222));
        rd_addr = 13'd31;
        tick();
        chk_eq("readback_31", rd_data, mkw(0, 0, 1, 'h201));
        enb = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grad_bram_seq.md
Name: grad_bram_seq

Overview:
- Parametrised, multi-channel successor to the single-stream gradient BRAM player.
- Holds a sample memory loaded through a simple write port, driven by the AXI-lite register wrapper.
- Plays words from a start offset at a programmable interval and tags each sample with a channel index.
- Supports per-word extra delays, end-of-sequence markers with optional looping, and serializer backpressure with a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 13, memory depth is 2^ADDR_WIDTH words of 32 bits.
- CHANNELS, 4, number of output channels. CH_W = $clog2(CHANNELS), minimum 1.
- DIV_WIDTH, 10, width of the interval divider.
- PAYLOAD_WIDTH, 24, sample width.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  memory write strobe.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_data_i  in  32  write word.
- rd_addr_i  in  ADDR_WIDTH  readback address.
- rd_data_o  out  32  readback data, 1-cycle latency.
- divider_i  in  DIV_WIDTH  interval = divider_i+4 cycles.
- offset_i  in  ADDR_WIDTH  start/loop address.
- data_enb_i  in  1  run enable.
- loop_i  in  1  restart at offset_i after a last word.
- serial_busy_i  in  1  serializer cannot accept a sample.
- clr_err_i  in  1  clears overflow_o.
- data_o  out  PAYLOAD_WIDTH  sample payload.
- channel_o  out  CH_W  sample channel.
- valid_o  out  1  1-cycle sample strobe.
- busy_o  out  1  sequencer running.
- done_o  out  1  1-cycle end-of-sequence pulse.
- overflow_o  out  1  sticky backpressure error.

Behaviour:
- Word format:
  - [31] last.
  - [30:28] D, the number of extra intervals after this sample.
  - [27:24] channel; the low CH_W bits are used.
  - [23:0] payload; the low PAYLOAD_WIDTH bits are used.
- Reset (async): state IDLE. data_o, channel_o, valid_o, busy_o, done_o, overflow_o and rd_data_o all go to 0. Memory contents are not reset.
- Memory: read-first. A write and a fetch to the same address in the same cycle returns the old word.
- States: IDLE, FETCH, EMIT, HOLD, DONE.
- IDLE:
  - If data_enb_i is high at an edge t0: address ← offset_i, busy_o=1, go to FETCH.
  - The first valid_o is asserted in cycle t0+3 (one cycle enable register, two cycles memory read).
- EMIT:
  - If serial_busy_i=0: data_o/channel_o update, valid_o=1 for one cycle, interval counter cleared, go to HOLD.
  - data_o/channel_o hold their values until the next strobe.
  - The next word is prefetched during HOLD. Since the minimum interval is 4 cycles, the prefetch always completes in time.
- Backpressure:
  - While serial_busy_i=1 in EMIT, the strobe is deferred. The interval counter keeps counting.
  - If the deferral reaches divider_i+4 cycles, overflow_o←1.
  - The sample is still emitted when busy falls, and the schedule shifts by the deferral.
- HOLD:
  - Ends when the counter ≥ (D+1)·(divider_i+4)−1.
  - divider_i is evaluated every cycle. If it is lowered below the elapsed count mid-pause, HOLD ends on the next cycle.
- Address after a non-last word: address+1, wrapping from 2^ADDR_WIDTH−1 to 0.
- After a last word's interval expires:
  - loop_i=1: address ← offset_i (re-sampled), continue.
  - loop_i=0: done_o pulses, busy_o=0, go to DONE.
- DONE: stays until data_enb_i=0, then goes to IDLE. A new run therefore needs enable to be toggled low and back high.
- data_enb_i=0 in any state: go to IDLE at the next edge. valid_o=0, busy_o=0, data_o held.
- offset_i is only sampled at start and at loop.
- clr_err_i clears overflow_o. If a set condition and a clear occur in the same cycle, the set wins.

Test Plan:
- Basic run:
  - Stimulus: words 0..9 with payload=k, ch=k%4, D=0, last on word 9; divider_i=0, offset_i=0, loop_i=0; data_enb_i rises at t0.
  - Response: strobes at t0+3+4k with payload k and channel k%4; done_o pulses 4 cycles after the k=9 strobe; busy_o=0.
- Delay and divider change:
  - Stimulus: divider_i=303, word with D=2.
  - Response: spacing 307 cycles, then 921 cycles after the D=2 word.
  - Stimulus: set divider_i=0 at cycle 100 of a pause.
  - Response: next strobe occurs on the following cycle.
- Backpressure:
  - Stimulus: serial_busy_i high for 100 cycles over a strobe point, divider_i=303.
  - Response: strobe deferred 100 cycles, overflow_o=0.
  - Stimulus: serial_busy_i high for 400 cycles.
  - Response: overflow_o=1, held until clr_err_i.
- Loop and wrap:
  - Stimulus: last on address 5, offset_i=2, loop_i=1.
  - Response: payload sequence 2,3,4,5,2,3,…
  - Stimulus: offset_i=8190 with ADDR_WIDTH=13.
  - Response: 8190, 8191, 0.
- Abort and reset:
  - Stimulus: data_enb_i low mid-HOLD.
  - Response: busy_o=0 next cycle.
  - Stimulus: S_AXI_ARESETN low mid-run with data_enb_i high.
  - Response: outputs 0 immediately; after release, first strobe 3 cycles later at offset_i.
- Read-first collision:
  - Stimulus: write the address being fetched in the same cycle.
  - Response: old word is emitted; rd_data_o returns the new word afterwards.
